// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera line-scan datapath.
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        READ,
        DRAIN,
        RELEASE
    } scan_state_t;

    // Tag fields are sized generously; controllers narrow them to their own widths.
    localparam int TAG_LINE_W = 16;
    localparam int TAG_COL_W  = 16;

    typedef struct packed {
        logic [TAG_LINE_W-1:0] line;
        logic [TAG_COL_W-1:0]  col;
        logic                  last_col;
        logic                  last_line;
    } pix_tag_t;

    // Bits needed to index 'count' items, never less than one.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/pixel_skid_buffer.sv
// Two-entry valid/ready buffer; occupancy is exported so the producer can
// run a credit scheme instead of watching a ready signal.
module pixel_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             pop;
    logic             push;

    assign pop  = out_valid && out_ready;
    assign push = in_valid && ((count_q != 2'd2) || pop);

    // Shift-style FIFO: the head register always holds the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= in_data;
                    else                 tail_q <= in_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_q <= tail_q;
                        tail_q <= in_data;
                    end else begin
                        head_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign occupancy = count_q;

endmodule

// File: rtl/line_scan_controller.sv
// Steps line_buffer through the frame, reads each captured line column by
// column and streams the pixels out over a valid/ready handshake.
module line_scan_controller
    import camera_pkg::*;
#(
    parameter int NUM_LINES   = 3,
    parameter int NUM_COLUMNS = 2,
    parameter int FIRST_LINE  = 0,
    parameter int LINE_STEP   = 1,
    parameter int DATA_W      = 8,
    localparam int LINE_W     = index_width(NUM_LINES),
    localparam int COL_W      = index_width(NUM_COLUMNS)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic              WHOLE_LINE_READY_FLAG,
    input  logic [DATA_W-1:0] BUF_DATA,
    output logic [LINE_W-1:0] INTERESTING_LINE,
    output logic [COL_W-1:0]  READ_ADDRESS,
    output logic              RESET_READY_FLAG,
    output logic [DATA_W-1:0] PIX_DATA,
    output logic [LINE_W-1:0] PIX_LINE,
    output logic [COL_W-1:0]  PIX_COLUMN,
    output logic              PIX_LAST_COL,
    output logic              PIX_LAST_LINE,
    output logic              PIX_VALID,
    input  logic              PIX_READY,
    output logic              BUSY
);

    localparam int TAG_BITS = $bits(pix_tag_t);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLUMNS - 1);

    scan_state_t       state_q, state_d;
    logic [LINE_W-1:0] line_q;
    logic [COL_W-1:0]  col_q;
    logic              rd_pending_q;
    pix_tag_t          rd_tag_q;
    logic              qualify_q;

    logic              issue;
    logic              credit;
    logic [1:0]        pipe_fill;
    logic [LINE_W:0]   line_sum;
    logic              line_wraps;
    logic [LINE_W-1:0] line_next;

    logic [1:0]                 skid_occ;
    logic                       skid_valid;
    logic                       skid_pop;
    logic [DATA_W+TAG_BITS-1:0] skid_head;
    pix_tag_t                   head_tag;
    logic                       unused_tag_bits;

    // Next line is formed one bit wider so the wrap test cannot overflow.
    assign line_sum   = {1'b0, line_q} + (LINE_W+1)'(LINE_STEP);
    assign line_wraps = (line_sum >= (LINE_W+1)'(NUM_LINES));
    assign line_next  = line_wraps ? LINE_W'(FIRST_LINE) : line_sum[LINE_W-1:0];

    // Entries still owed to the skid once this cycle's pop has left; a read
    // issued now lands in the skid two edges later.
    assign skid_pop  = skid_valid && PIX_READY;
    assign pipe_fill = skid_occ - {1'b0, skid_pop} + {1'b0, rd_pending_q};
    assign credit    = (pipe_fill < 2'd2);

    // Scan state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode and read issue.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ENABLE) state_d = WAIT_LINE;
            end
            WAIT_LINE: begin
                if (!ENABLE)                                   state_d = IDLE;
                else if (WHOLE_LINE_READY_FLAG && !qualify_q)  state_d = READ;
            end
            READ: begin
                issue = credit;
                if (credit && (col_q == COL_LAST)) state_d = DRAIN;
            end
            DRAIN: begin
                if ((skid_occ == 2'd0) && !rd_pending_q) state_d = RELEASE;
            end
            RELEASE: begin
                state_d = ENABLE ? WAIT_LINE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line/column counters, in-flight read tracking and the stale-flag guard.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            line_q       <= LINE_W'(FIRST_LINE);
            col_q        <= '0;
            rd_pending_q <= 1'b0;
            rd_tag_q     <= '0;
            qualify_q    <= 1'b0;
        end else begin
            rd_pending_q <= issue;
            qualify_q    <= (state_q == RELEASE);
            if (issue) begin
                rd_tag_q.line      <= TAG_LINE_W'(line_q);
                rd_tag_q.col       <= TAG_COL_W'(col_q);
                rd_tag_q.last_col  <= (col_q == COL_LAST);
                rd_tag_q.last_line <= line_wraps;
            end
            if (state_q == WAIT_LINE)  col_q <= '0;
            else if (issue)            col_q <= (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            if (state_q == RELEASE)    line_q <= line_next;
        end
    end

    pixel_skid_buffer #(
        .WIDTH (DATA_W + TAG_BITS)
    ) u_skid (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .in_valid  (rd_pending_q),
        .in_data   ({BUF_DATA, rd_tag_q}),
        .out_valid (skid_valid),
        .out_ready (PIX_READY),
        .out_data  (skid_head),
        .occupancy (skid_occ)
    );

    assign head_tag        = pix_tag_t'(skid_head[TAG_BITS-1:0]);
    assign unused_tag_bits = ^{head_tag.line[TAG_LINE_W-1:LINE_W], head_tag.col[TAG_COL_W-1:COL_W]};

    assign PIX_VALID        = skid_valid;
    assign PIX_DATA         = skid_head[DATA_W+TAG_BITS-1:TAG_BITS];
    assign PIX_LINE         = head_tag.line[LINE_W-1:0];
    assign PIX_COLUMN       = head_tag.col[COL_W-1:0];
    assign PIX_LAST_COL     = head_tag.last_col;
    assign PIX_LAST_LINE    = head_tag.last_line;
    assign INTERESTING_LINE = line_q;
    assign READ_ADDRESS     = col_q;
    assign RESET_READY_FLAG = (state_q == RELEASE);
    assign BUSY             = (state_q != IDLE);

endmodule

// File: doc/line_scan_controller.md
# line_scan_controller

Sequencer that drives `line_buffer` so that every selected camera line is captured, read out and released in turn. It steps `INTERESTING_LINE` through the frame, waits for `WHOLE_LINE_READY_FLAG`, and walks `READ_ADDRESS` across all columns. It streams the pixels downstream over a valid/ready handshake, then pulses `RESET_READY_FLAG` and advances to the next line. It sits between `line_buffer` and any pixel consumer, in the `CLK` domain of `line_buffer`.

## Interface
Parameters:
- `NUM_LINES`, 3: lines per frame. `LINE_W = $clog2(NUM_LINES)`, default 2.
- `NUM_COLUMNS`, 2: pixels per line. `COL_W = $clog2(NUM_COLUMNS)`, default 1.
- `FIRST_LINE`, 0: first line scanned after reset and after each wrap.
- `LINE_STEP`, 1: line increment; 1 scans every line, 2 every other line.
- `DATA_W`, 8: pixel width.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: system clock, same clock as `line_buffer`.
- `RESET_N` in 1: asynchronous active-low reset.
- `ENABLE` in 1: run the scan. When deasserted, the current line finishes, then the block idles.
- `WHOLE_LINE_READY_FLAG` in 1: from `line_buffer`.
- `BUF_DATA` in DATA_W: `line_buffer` `DATA_OUT`, valid 1 cycle after `READ_ADDRESS`.
- `INTERESTING_LINE` out LINE_W: line `line_buffer` captures.
- `READ_ADDRESS` out COL_W: column being read.
- `RESET_READY_FLAG` out 1: one-cycle release pulse.
- `PIX_DATA` out DATA_W: pixel.
- `PIX_LINE` out LINE_W, `PIX_COLUMN` out COL_W: coordinates of `PIX_DATA`.
- `PIX_LAST_COL` out 1: last pixel of line.
- `PIX_LAST_LINE` out 1: pixel belongs to last scanned line of frame.
- `PIX_VALID` out 1, `PIX_READY` in 1: downstream handshake.
- `BUSY` out 1: state ≠ IDLE.

## Operation
States:
- IDLE: `ENABLE`=1 → WAIT_LINE.
- WAIT_LINE: `WHOLE_LINE_READY_FLAG`=1 (qualified, see Timing) → READ, column counter=0.
- READ: issue `READ_ADDRESS`=col when credit available. Credit means skid occupancy + in-flight reads < 2. After issuing col=NUM_COLUMNS-1 → DRAIN.
- DRAIN: wait until skid empty and no read in flight → RELEASE.
- RELEASE, 1 cycle:
  - `RESET_READY_FLAG`=1.
  - `INTERESTING_LINE` ← next line: line+LINE_STEP, or FIRST_LINE if the sum ≥ NUM_LINES. Compute the sum at LINE_W+1 bits.
  - → WAIT_LINE if `ENABLE`, else IDLE.

Output path:
- Read data is captured into a 2-entry skid buffer tagged {line, col, last_col, last_line}.
- `PIX_*` show the head entry.
- Transfer occurs when `PIX_VALID && PIX_READY`.
- Pixel order is strictly ascending column, no drops, no duplicates.

## Timing
- Reset values:
  - state IDLE.
  - `INTERESTING_LINE`=FIRST_LINE.
  - `READ_ADDRESS`=0.
  - `RESET_READY_FLAG`=0.
  - `PIX_VALID`=0; `PIX_DATA`, `PIX_LINE`, `PIX_COLUMN`, `PIX_LAST_*`=0.
  - `BUSY`=0.
- Read latency:
  - Address issued in cycle t; `BUF_DATA` captured at end of t+1.
  - Earliest `PIX_VALID` in t+2.
  - With `PIX_READY` held high: one pixel per cycle, line throughput NUM_COLUMNS cycles + 2 fill.
- Backpressure: `PIX_READY`=0 stops issue after at most 2 outstanding entries. `PIX_*` stay stable while `PIX_VALID && !PIX_READY`.
- Flag qualification: in the cycle after RELEASE, WAIT_LINE ignores `WHOLE_LINE_READY_FLAG`, because the clear in `line_buffer` is registered. The flag is sampled from the second cycle onward.
- `INTERESTING_LINE` changes only in RELEASE. It never changes while the flag is set or the line is being read.
- Flag already high on entering WAIT_LINE (after the qualify cycle): READ begins next cycle.
- `ENABLE` drop during WAIT_LINE → IDLE immediately. During READ/DRAIN it is ignored until RELEASE.
- Reset mid-line:
  - All state clears and the skid empties.
  - No `RESET_READY_FLAG` pulse. `line_buffer` is reset by the same `RESET_N`.
- Wrap: NUM_LINES=3, STEP=2, FIRST=0 → lines 0, 2, 0, … `PIX_LAST_LINE`=1 on line 2.

## Structure
- Shared package `camera_pkg`: state enum {IDLE, WAIT_LINE, READ, DRAIN, RELEASE}, `pix_tag_t` struct {line, col, last_col, last_line}, width helper functions.
- Sub-module `pixel_skid_buffer`: 2-entry valid/ready buffer, parameterised on payload width, exposes occupancy for credit. The controller FSM, counters and credit logic stay in `line_scan_controller`.

## Test plan
Defaults unless stated; benches pair the block with `camera` + `line_buffer` models.
- Single line: frame with lines {11,12},{21,22},{31,32}, `PIX_READY`=1 → line 0 pixels 11, 12 with `PIX_LAST_COL` on 12. `RESET_READY_FLAG` pulses once. `INTERESTING_LINE` becomes 1.
- Full frame: 2 frames → output 11,12,21,22,31,32 twice. `PIX_LAST_LINE`=1 only on 31, 32. `INTERESTING_LINE` wraps 2→0.
- Backpressure: `PIX_READY` toggles 1,0,0,1 → no loss or duplication; `PIX_*` stable during stall; ≤2 reads outstanding.
- Step: LINE_STEP=2 → output 11,12,31,32; line 1 never read.
- Stale flag: `line_buffer` flag clear delayed 1 cycle → no second readout of the same line.
- Reset mid-READ after 1 pixel: `RESET_N` low 1 cycle → all outputs at reset values, `BUSY`=0. Next frame restarts at line 0 with pixel 11.
